// File: rtl/nn_pkg.sv
// nn_pkg: shared widths, backprop FSM states and the saturating subtract
// used by bp_lane when NEURON_BP_SATURATE_EN is defined.
package nn_pkg;

    localparam int DATA_W_DEFAULT = 32;

    typedef logic signed [DATA_W_DEFAULT-1:0] nn_word_t;

    typedef enum logic [1:0] {BP_IDLE, BP_CALC, BP_EMIT, BP_DONE} bp_state_t;

    // Operands arrive sign-extended to 64 bits, so the difference is exact; clamp to a w-bit signed range.
    function automatic longint sat_sub(input longint a, input longint b, input int w);
        longint d;
        longint hi;
        longint lo;
        d = a - b;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        return d > hi ? hi : (d < lo ? lo : d);
    endfunction

endpackage

// File: rtl/bp_lane.sv
// bp_lane: one backprop lane, gated error times input/weight -> updated weight and propagated error.
// NEURON_BP_SATURATE_EN selects a saturating weight subtraction instead of wrapping.
module bp_lane import nn_pkg::*; #(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int LR_SHIFT = 8
) (
    input  logic signed [DATA_W-1:0] delta_eff,
    input  logic signed [DATA_W-1:0] x_i,
    input  logic signed [DATA_W-1:0] w_i,
    output logic signed [DATA_W-1:0] w_new_i,
    output logic signed [DATA_W-1:0] err_prev_i
);

    logic signed [DATA_W-1:0] grad;
    logic signed [DATA_W-1:0] step;

    assign grad = delta_eff * x_i;
    assign step = grad >>> LR_SHIFT;

`ifdef NEURON_BP_SATURATE_EN
    assign w_new_i = DATA_W'(sat_sub(longint'(w_i), longint'(step), DATA_W));
`else
    assign w_new_i = w_i - step;
`endif

    assign err_prev_i = delta_eff * w_i;

endmodule

// File: rtl/neuron_backprop_serial.sv
// neuron_backprop_serial: serial backward pass of a ReLU neuron, one lane per output handshake.
// Define NEURON_BP_SATURATE_EN to saturate the weight update on signed overflow.
module neuron_backprop_serial import nn_pkg::*; #(
    parameter int INPUT_COUNT = 4,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int LR_SHIFT = 8,
    localparam int IW = INPUT_COUNT > 1 ? $clog2(INPUT_COUNT) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [DATA_W-1:0] delta,
    input  logic [DATA_W-1:0] result,
    input  logic [DATA_W-1:0] x [INPUT_COUNT],
    input  logic [DATA_W-1:0] w_in [INPUT_COUNT],
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IW-1:0]     out_idx,
    output logic [DATA_W-1:0] w_new,
    output logic [DATA_W-1:0] err_prev,
    output logic              done
);

    bp_state_t state, state_n;
    logic [IW-1:0] idx;
    logic [DATA_W-1:0] delta_r;
    logic [DATA_W-1:0] x_r [INPUT_COUNT];
    logic [DATA_W-1:0] w_r [INPUT_COUNT];
    logic signed [DATA_W-1:0] lane_w;
    logic signed [DATA_W-1:0] lane_e;
    logic last;

    assign last = idx == IW'(INPUT_COUNT - 1);
    assign out_idx = idx;

    bp_lane #(.DATA_W(DATA_W), .LR_SHIFT(LR_SHIFT)) u_lane (
        .delta_eff (delta_r),
        .x_i       (x_r[idx]),
        .w_i       (w_r[idx]),
        .w_new_i   (lane_w),
        .err_prev_i(lane_e)
    );

    always_comb begin
        start_ready = state == BP_IDLE;
        out_valid   = state == BP_EMIT;
        done        = state == BP_DONE;
        state_n = state == BP_IDLE ? (start_valid ? BP_CALC : BP_IDLE) :
                  state == BP_CALC ? BP_EMIT :
                  state == BP_EMIT ? (out_ready ? (last ? BP_DONE : BP_CALC) : BP_EMIT) :
                  BP_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BP_IDLE;
            idx      <= '0;
            delta_r  <= '0;
            w_new    <= '0;
            err_prev <= '0;
            for (int i = 0; i < INPUT_COUNT; i++) begin
                x_r[i] <= '0;
                w_r[i] <= '0;
            end
        end else begin
            state <= state_n;
            // ReLU derivative folded into the captured error: non-positive output kills the gradient.
            if (start_valid && start_ready) begin
                delta_r <= $signed(result) > 0 ? delta : '0;
                x_r     <= x;
                w_r     <= w_in;
                idx     <= '0;
            end
            if (state == BP_CALC) begin
                w_new    <= lane_w;
                err_prev <= lane_e;
            end
            if (out_valid && out_ready && !last)
                idx <= idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_neuron_backprop_serial.sv
// tb_neuron_backprop_serial: directed vectors with a beat scoreboard checked by an independent monitor.
module tb_neuron_backprop_serial;

    localparam int N = 4;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_valid = 1'b0;
    logic start_ready;
    logic [W-1:0] delta = '0;
    logic [W-1:0] result = '0;
    logic [W-1:0] x [N];
    logic [W-1:0] w_in [N];
    logic out_valid;
    logic out_ready = 1'b1;
    logic [1:0] out_idx;
    logic [W-1:0] w_new;
    logic [W-1:0] err_prev;
    logic done;

    typedef struct packed {
        logic [1:0]   idx;
        logic [W-1:0] w;
        logic [W-1:0] e;
    } beat_t;

    beat_t q[$];
    int vectors = 0;
    int miscompares = 0;
    bit exp_done = 0;

    logic [W-1:0] jx [N];
    logic [W-1:0] jw [N];
    logic [W-1:0] ew [N];
    logic [W-1:0] ee [N];

    always #5 clk = ~clk;

    neuron_backprop_serial #(.INPUT_COUNT(N), .DATA_W(W), .LR_SHIFT(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .delta(delta), .result(result), .x(x), .w_in(w_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .w_new(w_new), .err_prev(err_prev), .done(done)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    always begin
        @(negedge clk);
        if (exp_done) begin
            chk("done_pulse", W'(done), 1);
            exp_done = 0;
        end else if (done)
            chk("stray_done", W'(done), 0);
        if (out_valid) begin
            if (q.size() == 0)
                fail($sformatf("unexpected_beat idx=%0d", out_idx));
            else begin
                chk(out_ready ? "idx" : "hold_idx", W'(out_idx), W'(q[0].idx));
                chk(out_ready ? "w_new" : "hold_w_new", w_new, q[0].w);
                chk(out_ready ? "err_prev" : "hold_err_prev", err_prev, q[0].e);
                if (out_ready) begin
                    if (q[0].idx == 2'(N - 1)) exp_done = 1;
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic start_job(input logic [W-1:0] d, input logic [W-1:0] r);
        int n = 0;
        while (!start_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("start_ready_idle", W'(start_ready), 1);
        delta = d;
        result = r;
        x = jx;
        w_in = jw;
        for (int i = 0; i < N; i++)
            q.push_back(beat_t'{idx: 2'(i), w: ew[i], e: ee[i]});
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(negedge clk);
        chk("lat_t1_valid", W'(out_valid), 0);
        @(negedge clk);
        chk("lat_t2_valid", W'(out_valid), 1);
    endtask

    task automatic wait_done(input bit scramble);
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            if (scramble) begin
                for (int i = 0; i < N; i++) begin
                    x[i] = $urandom;
                    w_in[i] = $urandom;
                end
                delta = $urandom;
                result = $urandom;
            end
            n++;
        end
        if (!done)
            fail("done_timeout");
        else begin
            chk("ready_in_done", W'(start_ready), 0);
            @(negedge clk);
            chk("ready_after_done", W'(start_ready), 1);
        end
    endtask

    task automatic load_basic();
        jx = '{32'd1, 32'd2, 32'd3, 32'd4};
        jw = '{32'd10, 32'd20, 32'd30, 32'd40};
        ew = '{32'd9, 32'd18, 32'd27, 32'd36};
        ee = '{32'd2560, 32'd5120, 32'd7680, 32'd10240};
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            x[i] = '0;
            w_in[i] = '0;
        end
        #12;
        chk("rst_start_ready", W'(start_ready), 1);
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_out_idx", W'(out_idx), 0);
        chk("rst_w_new", w_new, 0);
        chk("rst_err_prev", err_prev, 0);
        chk("rst_done", W'(done), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // basic update
        load_basic();
        start_job(32'd256, 32'd5);
        wait_done(0);

        // ReLU gate, result zero then negative
        load_basic();
        ew = jw;
        ee = '{32'd0, 32'd0, 32'd0, 32'd0};
        start_job(32'd256, 32'd0);
        wait_done(0);
        start_job(32'd256, 32'hFFFF_FFF9);
        wait_done(0);

        // backpressure on idx 1, with a stray start request
        load_basic();
        start_job(32'd256, 32'd5);
        begin
            int n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!(out_valid && out_idx == 2'd1) && n < 20);
        end
        chk("bp_reach_idx1", W'(out_valid && out_idx == 2'd1), 1);
        out_ready = 1'b0;
        start_valid = 1'b1;
        chk("bp_start_ready_busy", W'(start_ready), 0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("bp_still_valid", W'(out_valid), 1);
        out_ready = 1'b1;
        start_valid = 1'b0;
        wait_done(0);

        // reset in the middle of EMIT idx 2
        load_basic();
        start_job(32'd256, 32'd5);
        begin
            int n = 0;
            while (!(out_valid && out_idx == 2'd2) && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        chk("rst_reach_idx2", W'(out_valid && out_idx == 2'd2), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", W'(out_valid), 0);
        chk("mid_rst_out_idx", W'(out_idx), 0);
        chk("mid_rst_w_new", w_new, 0);
        chk("mid_rst_err_prev", err_prev, 0);
        chk("mid_rst_done", W'(done), 0);
        chk("mid_rst_start_ready", W'(start_ready), 1);
        q.delete();
        exp_done = 0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        load_basic();
        start_job(32'd256, 32'd5);
        wait_done(0);

        // overflow on lane 0
        jx = '{32'd4096, 32'd0, 32'd0, 32'd0};
        jw = '{32'h7FFF_FFF0, 32'h7FFF_FFF0, 32'h7FFF_FFF0, 32'h7FFF_FFF0};
`ifdef NEURON_BP_SATURATE_EN
        ew = '{32'h7FFF_FFFF, 32'h7FFF_FFF0, 32'h7FFF_FFF0, 32'h7FFF_FFF0};
`else
        ew = '{32'h8000_0FF0, 32'h7FFF_FFF0, 32'h7FFF_FFF0, 32'h7FFF_FFF0};
`endif
        ee = '{32'd4096, 32'd4096, 32'd4096, 32'd4096};
        start_job(32'hFFFF_FF00, 32'd1);
        wait_done(0);

        // input isolation and back-to-back jobs
        load_basic();
        start_job(32'd256, 32'd5);
        wait_done(1);
        load_basic();
        ew = '{32'd11, 32'd22, 32'd33, 32'd44};
        ee = '{-32'sd2560, -32'sd5120, -32'sd7680, -32'sd10240};
        start_job(32'hFFFF_FF00, 32'd3);
        wait_done(1);

        repeat (5) @(negedge clk);
        chk("queue_drained", W'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
